text_char_buffer: RTL

//  Character-cell text buffer plus font lookup; the responder on the char_xy/char_line ->

---
 rtl/text_char_buffer_pkg.sv | 27 ++
 rtl/text_char_buffer_if.sv | 25 ++
 rtl/text_char_buffer_font_rom.sv | 53 +++++
 rtl/text_char_buffer.sv | 117 +++++++++++
 4 files changed

// File: rtl/text_char_buffer_pkg.sv
// Shared sizes, command encoding and FSM states for the character-cell text buffer.
package text_char_buffer_pkg;

  localparam int unsigned TEXT_COLS = 16;
  localparam int unsigned TEXT_ROWS = 16;
  localparam int unsigned CELLS     = TEXT_COLS * TEXT_ROWS;
  localparam int unsigned ADDR_W    = $clog2(CELLS);
  localparam int unsigned CHAR_W    = 8;
  localparam int unsigned LINE_W    = 4;
  localparam int unsigned CODE_W    = 7;
  localparam int unsigned FONT_AW   = CODE_W + LINE_W;

  localparam logic [CHAR_W-1:0] CHAR_SPACE = 8'h20;

  typedef enum logic [1:0] {
    CMD_PUT    = 2'd0,
    CMD_SETCUR = 2'd1,
    CMD_CLEAR  = 2'd2,
    CMD_NOP    = 2'd3
  } cmd_t;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

endpackage

// File: rtl/text_char_buffer_if.sv
// Drawer read port (char_xy/char_line -> char_pixels) and the grid command port.
interface text_char_buffer_if;
  import text_char_buffer_pkg::*;

  logic [ADDR_W-1:0] char_xy;
  logic [LINE_W-1:0] char_line;
  logic [CHAR_W-1:0] char_pixels;
  logic              wr_valid;
  logic              wr_ready;
  cmd_t              wr_cmd;
  logic [CHAR_W-1:0] wr_data;
  logic [ADDR_W-1:0] cursor;
  logic              busy;

  modport master (
    output char_xy, char_line, wr_valid, wr_cmd, wr_data,
    input  char_pixels, wr_ready, cursor, busy
  );

  modport slave (
    input  char_xy, char_line, wr_valid, wr_cmd, wr_data,
    output char_pixels, wr_ready, cursor, busy
  );

endinterface

// File: rtl/text_char_buffer_font_rom.sv
// Synchronous glyph ROM: address {code[6:0], line}, returns one 8-pixel row (bit 7 leftmost).
module text_char_buffer_font_rom
  import text_char_buffer_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [FONT_AW-1:0] i_addr,
  output logic [CHAR_W-1:0]  o_data
);

  localparam int unsigned GLYPH_W = 80;

  // Glyph bodies occupy lines 2..11, first byte is line 2.
  localparam logic [GLYPH_W-1:0] G_A   = 80'h10_38_6C_C6_C6_FE_C6_C6_C6_C6;
  localparam logic [GLYPH_W-1:0] G_B   = 80'hFC_66_66_66_7C_66_66_66_66_FC;
  localparam logic [GLYPH_W-1:0] G_C   = 80'h3C_66_C2_C0_C0_C0_C0_C2_66_3C;
  localparam logic [GLYPH_W-1:0] G_D   = 80'hF8_6C_66_66_66_66_66_66_6C_F8;
  localparam logic [GLYPH_W-1:0] G_BOX = 80'h7E_42_42_42_42_42_42_42_42_7E;

  logic [GLYPH_W-1:0] w_glyph;
  logic [GLYPH_W-1:0] w_shift;
  logic [LINE_W-1:0]  w_line;
  logic [LINE_W-1:0]  w_k;
  logic [CHAR_W-1:0]  w_row;

  always_comb begin
    w_glyph = G_BOX;
    case (i_addr[FONT_AW-1:LINE_W])
      7'h20:   w_glyph = '0;
      7'h41:   w_glyph = G_A;
      7'h42:   w_glyph = G_B;
      7'h43:   w_glyph = G_C;
      7'h44:   w_glyph = G_D;
      default: w_glyph = G_BOX;
    endcase
    w_line  = i_addr[LINE_W-1:0];
    w_k     = w_line - 4'd2;
    w_shift = w_glyph << {w_k, 3'b000};
    w_row   = 8'h00;
    if (w_line >= 4'd2 && w_line <= 4'd11) begin
      w_row = w_shift[GLYPH_W-1 -: CHAR_W];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_data <= '0;
    end else begin
      o_data <= w_row;
    end
  end

endmodule

// File: rtl/text_char_buffer.sv
// 16x16 character grid with a two-cycle glyph read path and a valid/ready fill port.
module text_char_buffer
  import text_char_buffer_pkg::*;
#(
  parameter logic [CHAR_W-1:0] FILL_CHAR  = CHAR_SPACE,
  parameter bit                INIT_CLEAR = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  text_char_buffer_if.slave  bus
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_clr_addr;
  logic [ADDR_W-1:0] w_clr_nxt;
  logic [ADDR_W-1:0] r_cursor;
  logic [ADDR_W-1:0] w_cursor_nxt;
  logic              r_ready;
  logic              r_busy;
  logic              w_accept;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [CHAR_W-1:0] w_wdata;

  logic [CHAR_W-1:0] r_ram [CELLS];
  logic [CODE_W-1:0] r_code;
  logic [LINE_W-1:0] r_line;
  logic [CHAR_W-1:0] w_pixels;

  // r_ready is only ever high in S_IDLE, so it alone qualifies the handshake.
  assign w_accept = bus.wr_valid & r_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= INIT_CLEAR ? S_CLEAR : S_IDLE;
      r_clr_addr <= '0;
      r_cursor   <= '0;
      r_ready    <= 1'b0;
      r_busy     <= INIT_CLEAR;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_addr <= w_clr_nxt;
      r_cursor   <= w_cursor_nxt;
      r_ready    <= (w_state_nxt == S_IDLE);
      r_busy     <= (w_state_nxt == S_CLEAR);
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_clr_nxt    = r_clr_addr;
    w_cursor_nxt = r_cursor;
    w_we         = 1'b0;
    w_waddr      = r_cursor;
    w_wdata      = bus.wr_data;
    case (r_state)
      S_CLEAR: begin
        w_we      = 1'b1;
        w_waddr   = r_clr_addr;
        w_wdata   = FILL_CHAR;
        w_clr_nxt = r_clr_addr + ADDR_W'(1);
        if (r_clr_addr == ADDR_W'(CELLS - 1)) begin
          w_state_nxt  = S_IDLE;
          w_cursor_nxt = '0;
        end
      end
      S_IDLE: begin
        if (w_accept) begin
          case (bus.wr_cmd)
            CMD_PUT: begin
              w_we         = 1'b1;
              w_cursor_nxt = r_cursor + ADDR_W'(1);
            end
            CMD_SETCUR: w_cursor_nxt = bus.wr_data;
            CMD_CLEAR: begin
              w_state_nxt = S_CLEAR;
              w_clr_nxt   = '0;
            end
            default: ;
          endcase
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_we) begin
      r_ram[w_waddr] <= w_wdata;
    end
  end

  // Read port sees the pre-write contents on a same-cycle hit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_code <= '0;
      r_line <= '0;
    end else begin
      r_code <= r_ram[bus.char_xy][CODE_W-1:0];
      r_line <= bus.char_line;
    end
  end

  text_char_buffer_font_rom u_font_rom (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_addr ({r_code, r_line}),
    .o_data (w_pixels)
  );

  assign bus.char_pixels = w_pixels;
  assign bus.wr_ready    = r_ready;
  assign bus.cursor      = r_cursor;
  assign bus.busy        = r_busy;

endmodule
